// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO write port.
// An op takes W RUN cycles plus one FIX cycle; busy holds the front of the pipe meanwhile.
module hilo_muldiv #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         mthi,
    input  logic         mtlo,
    input  logic [W-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);
    localparam int CW = (W > 2) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc;       // mult: {partial hi, multiplier}; div: {remainder, quotient}
    logic [W-1:0]   dvs;       // multiplicand or divisor magnitude
    logic           is_div, neg_lo, neg_hi, dz;

    logic           launch, mt_ok;
    logic           a_neg, b_neg;
    logic [W-1:0]   a_mag, b_mag;
    logic [W:0]     sum, shl, diff;
    logic [2*W-1:0] step, prod_fix;
    logic [W-1:0]   q_fix, r_fix;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == '0) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs and control decodes; busy depends on state only, never on start
    always_comb begin
        busy   = (state != IDLE);
        launch = (state == IDLE) && start;
        mt_ok  = (state == IDLE) && !start;
    end

    // Operand magnitudes fit in W unsigned bits, so -0x80000000 maps to 0x80000000 exactly
    always_comb begin
        a_neg = !op[0] && a[W-1];
        b_neg = !op[0] && b[W-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    // One shift-add or restoring shift-subtract iteration
    always_comb begin
        sum  = {1'b0, acc[2*W-1:W]} + {1'b0, dvs};
        shl  = {acc[2*W-1:W], acc[W-1]};
        diff = shl - {1'b0, dvs};
        step = '0;
        if (is_div) begin
            if (!diff[W]) step = {diff[W-1:0], acc[W-2:0], 1'b1};
            else          step = {shl[W-1:0],  acc[W-2:0], 1'b0};
        end else begin
            if (acc[0])   step = {sum, acc[W-1:1]};
            else          step = {1'b0, acc[2*W-1:1]};
        end
    end

    // Sign correction; with a zero divisor the remainder is |a| and re-signs back to a
    always_comb begin
        prod_fix = neg_lo ? -acc : acc;
        r_fix    = neg_hi ? -acc[2*W-1:W] : acc[2*W-1:W];
        if (dz)          q_fix = '1;
        else if (neg_lo) q_fix = -acc[W-1:0];
        else             q_fix = acc[W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            dvs    <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            dz     <= 1'b0;
        end else if (launch) begin
            cnt    <= CW'(W - 1);
            acc    <= {{W{1'b0}}, (op[1] ? a_mag : b_mag)};
            dvs    <= op[1] ? b_mag : a_mag;
            is_div <= op[1];
            neg_lo <= a_neg ^ b_neg;
            neg_hi <= op[1] && a_neg;
            dz     <= op[1] && (b == '0);
        end else if (state == RUN) begin
            cnt <= cnt - 1'b1;
            acc <= step;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= (state == FIX);
            if (state == FIX) begin
                hi <= is_div ? r_fix : prod_fix[2*W-1:W];
                lo <= is_div ? q_fix : prod_fix[W-1:0];
            end else if (mt_ok) begin
                if (mthi) hi <= wdata;
                if (mtlo) lo <= wdata;
            end
        end
    end
endmodule
